// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream ingress and word-write memory bus of the program loader.
//   in_valid/in_ready/in_data/in_last : byte source handshake (master drives valid/data/last)
//   mem_we/mem_addr/mem_wdata         : one-cycle word write strobe toward target memory
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // master: byte source / memory observer side
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // slave: the loader itself
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: packs a little-endian byte stream into 32-bit words, writes them to
// target memory, releases the MIPS core from reset and captures A0 when V0 signals exit.
// Ports: clk_i/rst_ni (async active-low), bus (prog_loader_if.slave: byte stream in,
//   memory write out), v0_i/a0_i core registers, cpu_reset_o, done_o, result_o,
//   not_found_o, load_err_o, timeout_o.
// Optional: define PROG_LOADER_WATCHDOG_EN to enable the RUN-state watchdog.
module prog_loader #(
  parameter int MEM_WORDS      = 256,
  parameter int EXIT_CODE      = 10,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  prog_loader_if.slave       bus,
  input  logic signed [31:0] v0_i,
  input  logic signed [31:0] a0_i,
  output logic               cpu_reset_o,
  output logic               done_o,
  output logic signed [31:0] result_o,
  output logic               not_found_o,
  output logic               load_err_o,
  output logic               timeout_o
);

  localparam int AW = $clog2(MEM_WORDS);
  // word index runs one past the last address so "memory full" is representable
  localparam logic [AW:0] MAX_IDX = (AW+1)'(MEM_WORDS);

  if (MEM_WORDS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("prog_loader: MEM_WORDS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic [1:0]         byte_cnt_q;
  logic [31:0]        word_buf_q;
  logic [AW:0]        word_idx_q;
  logic               rel_cnt_q;
  logic               mem_we_q;
  logic [AW-1:0]      mem_addr_q;
  logic [31:0]        mem_wdata_q;
  logic               cpu_reset_q;
  logic               done_q;
  logic signed [31:0] result_q;
  logic               not_found_q;
  logic               load_err_q;

`ifdef PROG_LOADER_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] run_cnt_q;
  logic          timeout_q;
`endif

  logic        xfer;
  logic [31:0] word_d;

  assign xfer = bus.in_valid & in_ready_q;

  // Buffer holds earlier bytes of the current word with upper lanes zero, so a
  // partial word on in_last comes out zero-filled without extra masking.
  always_comb begin
    word_d = word_buf_q | (32'(bus.in_data) << {byte_cnt_q, 3'b000});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_LOAD;
      in_ready_q  <= 1'b0;
      byte_cnt_q  <= '0;
      word_buf_q  <= '0;
      word_idx_q  <= '0;
      rel_cnt_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
      not_found_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef PROG_LOADER_WATCHDOG_EN
      run_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (word_idx_q == MAX_IDX) begin
              // memory already full: drop the byte rather than wrap the address
              state_q    <= S_ERR;
              load_err_q <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (byte_cnt_q == 2'd3 || bus.in_last) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx_q[AW-1:0];
              mem_wdata_q <= word_d;
              word_idx_q  <= word_idx_q + (AW+1)'(1);
              byte_cnt_q  <= '0;
              word_buf_q  <= '0;
              if (bus.in_last) begin
                state_q    <= S_RELEASE;
                in_ready_q <= 1'b0;
                rel_cnt_q  <= 1'b0;
              end
            end else begin
              word_buf_q <= word_d;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end

        // two cycles of held reset after the final write strobe
        S_RELEASE: begin
          if (rel_cnt_q) begin
            state_q     <= S_RUN;
            cpu_reset_q <= 1'b0;
          end else begin
            rel_cnt_q <= 1'b1;
          end
        end

        S_RUN: begin
          // exit wins over a watchdog expiry on the same edge
          if (v0_i == EXIT_CODE) begin
            result_q    <= a0_i;
            not_found_q <= (a0_i == -32'sd1);
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            state_q     <= S_DONE;
          end
`ifdef PROG_LOADER_WATCHDOG_EN
          else if (run_cnt_q == RUN_LAST) begin
            timeout_q   <= 1'b1;
            cpu_reset_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            run_cnt_q <= run_cnt_q + CW'(1);
          end
`endif
        end

        // DONE and ERR are terminal: everything holds until reset
        default: begin
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset_o   = cpu_reset_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign not_found_o   = not_found_q;
  assign load_err_o    = load_err_q;
`ifdef PROG_LOADER_WATCHDOG_EN
  assign timeout_o     = timeout_q;
`else
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader with a write scoreboard.
// Ports: none (top level); drives the byte stream and core registers, checks outputs.
module tb_prog_loader;
  localparam int MW   = 4;
  localparam int AW   = 2;
  localparam int EXIT = 10;
  localparam int TO   = 200;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [31:0] v0 = EXIT;
  logic signed [31:0] a0 = '0;
  logic cpu_reset, done, not_found, load_err, timeout;
  logic signed [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [7:0] img[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(
    .MEM_WORDS(MW),
    .EXIT_CODE(EXIT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .v0_i       (v0),
    .a0_i       (a0),
    .cpu_reset_o(cpu_reset),
    .done_o     (done),
    .result_o   (result),
    .not_found_o(not_found),
    .load_err_o (load_err),
    .timeout_o  (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe seen must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  // Reference: image bytes grouped four at a time, little-endian, zero-filled,
  // at most MW words stored.
  function automatic void build_expect(input int n);
    int nw;
    nw = (n > 4*MW) ? MW : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.addr = AW'(w);
      e.data = '0;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = 4*w + k;
        if (idx < n && idx < 4*MW) e.data = e.data + (32'(img[idx]) << (8*k));
      end
      exp_q.push_back(e);
    end
  endfunction

  function automatic logic signed [31:0] non_exit();
    logic signed [31:0] v;
    v = $urandom;
    if (v == EXIT) v = EXIT + 1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    v0 = EXIT;  // must be ignored until RUN
    #1;
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_mem_we",    32'(bus.mem_we), 0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done",      32'(done), 0);
    chk("rst_result",    result, 0);
    chk("rst_not_found", 32'(not_found), 0);
    chk("rst_load_err",  32'(load_err), 0);
    chk("rst_timeout",   32'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer one byte with random idle gaps; returns right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int  budget;
    bit  taken;
    budget = 0;
    taken  = 0;
    while (!taken) begin
      @(negedge clk);
      if (budget > 100) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout: got in_ready stuck %b, expected acceptance", bus.in_ready);
        break;
      end
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = b;
      bus.in_last  = last;
      if (bus.in_valid && bus.in_ready) taken = 1;
      budget++;
    end
    @(posedge clk);
  endtask

  // Streams img; on success returns at the first negedge where cpu_reset is low.
  task automatic load_image(output bit ovf);
    int n;
    n = img.size();
    ovf = (n > 4*MW);
    build_expect(n);
    for (int i = 0; i < n; i++) send_byte(img[i], (i == n-1) && !ovf);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (ovf) begin
      chk("err_load_err",  32'(load_err), 1);
      chk("err_in_ready",  32'(bus.in_ready), 0);
      chk("err_cpu_reset", 32'(cpu_reset), 1);
      chk("err_mem_we",    32'(bus.mem_we), 0);
      v0 = EXIT;
      a0 = 5;
      repeat (3) @(negedge clk);
      chk("err_hold_done",      32'(done), 0);
      chk("err_hold_load_err",  32'(load_err), 1);
      chk("err_hold_cpu_reset", 32'(cpu_reset), 1);
    end else begin
      chk("ld_in_ready_low", 32'(bus.in_ready), 0);
      chk("ld_last_strobe",  32'(bus.mem_we), 1);
      chk("rel_cpu_reset_1", 32'(cpu_reset), 1);
      @(negedge clk);
      chk("rel_cpu_reset_2", 32'(cpu_reset), 1);
      @(negedge clk);
      chk("run_cpu_reset", 32'(cpu_reset), 0);
      chk("run_done_low",  32'(done), 0);
      v0 = non_exit();
    end
  endtask

  task automatic run_exit(input logic signed [31:0] val);
    int idle;
    idle = $urandom_range(0, 15);
    repeat (idle) begin
      v0 = non_exit();
      a0 = $urandom;
      @(negedge clk);
    end
    chk("pre_exit_done", 32'(done), 0);
    chk("pre_exit_cpu_reset", 32'(cpu_reset), 0);
    a0 = val;
    v0 = EXIT;
    @(negedge clk);
    chk("exit_done",      32'(done), 1);
    chk("exit_result",    result, val);
    chk("exit_not_found", 32'(not_found), (val == -32'sd1) ? 32'd1 : 32'd0);
    chk("exit_cpu_reset", 32'(cpu_reset), 1);
    chk("exit_timeout",   32'(timeout), 0);
    v0 = non_exit();
    a0 = $urandom;
    repeat (3) @(negedge clk);
    chk("hold_result",   result, val);
    chk("hold_done",     32'(done), 1);
    chk("hold_in_ready", 32'(bus.in_ready), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ovf;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // directed: two full words
    do_reset();
    img.delete();
    for (int i = 1; i <= 8; i++) img.push_back(8'(i));
    load_image(ovf);
    if (!ovf) run_exit(32'sd3);

    // directed: partial trailing word
    do_reset();
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_image(ovf);
    if (!ovf) run_exit(-32'sd1);

    // directed: overflow by one byte
    do_reset();
    img.delete();
    for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
    load_image(ovf);

    // randomized images and exit values
    for (int t = 0; t < 10; t++) begin
      int n;
      logic signed [31:0] val;
      do_reset();
      img.delete();
      n = (t == 0) ? 16 : $urandom_range(1, 17);
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      case ($urandom_range(0, 2))
        0:       val = -32'sd1;
        1:       val = 32'sd3;
        default: val = $urandom;
      endcase
      load_image(ovf);
      if (!ovf) run_exit(val);
    end

    // reset in the middle of a load kills the pending strobe and partial word
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    #1 chk("pre_reset_strobe", 32'(bus.mem_we), 1);
    #1 rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_mem_we",    32'(bus.mem_we), 0);
    chk("midrst_mem_addr",  32'(bus.mem_addr), 0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 1);
    @(negedge clk);
    rst_n = 1'b1;
    img = '{8'h55, 8'h66, 8'h77, 8'h88};
    load_image(ovf);
    if (!ovf) run_exit($urandom);

    // long RUN without exit
    do_reset();
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_image(ovf);
`ifdef PROG_LOADER_WATCHDOG_EN
    repeat (TO - 1) @(negedge clk);
    chk("wd_before_timeout", 32'(timeout), 0);
    chk("wd_before_cpu_reset", 32'(cpu_reset), 0);
    @(negedge clk);
    chk("wd_timeout", 32'(timeout), 1);
    chk("wd_done", 32'(done), 0);
    chk("wd_cpu_reset", 32'(cpu_reset), 1);
    v0 = EXIT;
    repeat (2) @(negedge clk);
    chk("wd_terminal_done", 32'(done), 0);
    chk("wd_terminal_timeout", 32'(timeout), 1);
`else
    repeat (250) @(negedge clk);
    chk("long_run_timeout", 32'(timeout), 0);
    chk("long_run_cpu_reset", 32'(cpu_reset), 0);
    chk("long_run_done", 32'(done), 0);
    run_exit(32'sd7);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit words in target memory.
REQ-002 Parameter EXIT_CODE, default 10, V0 value signalling program exit.
REQ-003 Parameter TIMEOUT_CYCLES, default 200, RUN-state cycle limit (watchdog only).
REQ-004 clock  input  1  single system clock, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  byte-stream source has a byte.
REQ-007 in_ready  output  1  loader accepts a byte this cycle.
REQ-008 in_data  input  8  image byte.
REQ-009 in_last  input  1  qualifies final byte of image.
REQ-010 mem_we  output  1  one-cycle word write strobe to memory.
REQ-011 mem_addr  output  log2(MEM_WORDS)  word address.
REQ-012 mem_wdata  output  32  assembled word.
REQ-013 cpu_reset  output  1  active-high reset held on the MIPS core.
REQ-014 v0, a0  input  32 each  core registers V0/A0, signed.
REQ-015 done  output  1  exit observed, result valid.
REQ-016 result  output  32  signed A0 captured at exit.
REQ-017 not_found  output  1  result equals -1.
REQ-018 load_err  output  1  image exceeded MEM_WORDS.
REQ-019 timeout  output  1  watchdog expired.

Function
REQ-020 States SHALL be LOAD, RELEASE, RUN, DONE, ERR; reset enters LOAD.
REQ-021 in_ready SHALL be 1 only in LOAD; transfer occurs when in_valid && in_ready.
REQ-022 Bytes SHALL pack little-endian: k-th byte of a word (k=0..3) into bits [8k+7:8k].
REQ-023 On 4th byte transfer, mem_we SHALL pulse for exactly the next cycle with mem_wdata=assembled word, mem_addr=current word index; index then increments.
REQ-024 in_last on a partial word SHALL write it with unfilled bytes zero; in_last on a 4th byte SHALL cause exactly one write.
REQ-025 After the final write, state SHALL go to RELEASE; cpu_reset held 2 further cycles, then deasserted on entering RUN.
REQ-026 A byte arriving after word MEM_WORDS-1 is written SHALL NOT be written (no address wrap); load_err=1, state ERR.
REQ-027 In RUN, when v0==EXIT_CODE at a rising edge, result<=a0, not_found<=(a0==-1), done<=1, cpu_reset<=1, state DONE, all same edge.
REQ-028 DONE and ERR SHALL be terminal until reset; outputs hold; in_ready=0, mem_we=0.
REQ-029 cpu_reset SHALL be 1 in every state except RUN.
REQ-030 v0/a0 SHALL be ignored outside RUN.

Reset
REQ-031 reset low SHALL immediately force: state LOAD, in_ready=0 until release, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, result=0, not_found=0, load_err=0, timeout=0, byte and cycle counters 0.
REQ-032 reset asserted mid-load or mid-run SHALL discard the partial word; no write SHALL issue after reset asserts.

Configuration
REQ-033 Macro PROG_LOADER_WATCHDOG_EN defined: RUN cycle counter; at TIMEOUT_CYCLES cycles without exit, timeout=1, cpu_reset=1, state DONE with done=0; exit on the same cycle as expiry takes priority.
REQ-034 Macro undefined: no counter; timeout tied 0; RUN persists until exit.

Verification
REQ-035 8 bytes 01 02 03 04 05 06 07 08, last on 08 -> writes addr0=32'h04030201, addr1=32'h08070605, 2 cycles later cpu_reset=0.
REQ-036 5 bytes AA BB CC DD EE, last on EE -> writes 32'hDDCCBBAA at 0, 32'h000000EE at 1, exactly 2 strobes.
REQ-037 In RUN drive a0=3 then v0=10 -> next edge done=1, result=3, not_found=0, cpu_reset=1.
REQ-038 In RUN a0=-1, v0=10 -> done=1, result=-1, not_found=1.
REQ-039 MEM_WORDS=4, 17 bytes -> 4 writes, load_err=1, state ERR, no 5th strobe, cpu_reset=1.
REQ-040 With PROG_LOADER_WATCHDOG_EN, TIMEOUT_CYCLES=200, v0 never 10 -> timeout=1 after 200 RUN cycles, done=0; reset low mid-load -> mem_we=0 immediately.
